// File: rtl/lbist_pkg.sv
// -----------------------------------------------------------------------------
// lbist_pkg
// Shared types and constants for the logic-BIST controller:
//   - lbist_state_e       : controller FSM state encoding
//   - LBIST_W             : pattern / response / signature width
//   - LBIST_DEFAULT_POLY  : Galois feedback polynomial used by LFSR and MISR
//   - LBIST_DEFAULT_SEED  : non-zero LFSR start state
//   - galois_step()       : one shift of a Galois register, optionally
//                           folding in a data word (MISR compaction)
// -----------------------------------------------------------------------------
package lbist_pkg;

    localparam int unsigned LBIST_W = 32;

    localparam logic [LBIST_W-1:0] LBIST_DEFAULT_POLY = 32'h8020_0003;
    localparam logic [LBIST_W-1:0] LBIST_DEFAULT_SEED = 32'hACE1_2468;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } lbist_state_e;

    // Right shift with the polynomial folded back in when a 1 falls out of
    // bit 0; din = 0 gives a plain LFSR, din = response gives a MISR.
    function automatic logic [LBIST_W-1:0] galois_step(
        input logic [LBIST_W-1:0] state,
        input logic [LBIST_W-1:0] poly,
        input logic [LBIST_W-1:0] din
    );
        logic [LBIST_W-1:0] fb;
        if (state[0]) begin
            fb = poly;
        end else begin
            fb = {LBIST_W{1'b0}};
        end
        return {1'b0, state[LBIST_W-1:1]} ^ fb ^ din;
    endfunction

endpackage

// File: rtl/lbist_controller_if.sv
// -----------------------------------------------------------------------------
// lbist_controller_if
// Bundles the BIST handshake and the core-under-test connection.
//   start_i      : BIST request level (from test flow)
//   resp_i       : core response word
//   pattern_o    : LFSR pattern applied to the core
//   test_mode_o  : core input mux select, 1 = BIST patterns
//   core_rst_no  : core reset request, active-low
//   done_o       : run finished
//   go_nogo_o    : 1 = signature matched
//   signature_o  : current MISR state (debug)
// master = test flow / core side, slave = controller side.
// -----------------------------------------------------------------------------
interface lbist_controller_if;
    import lbist_pkg::*;

    logic               start_i;
    logic [LBIST_W-1:0] resp_i;
    logic [LBIST_W-1:0] pattern_o;
    logic               test_mode_o;
    logic               core_rst_no;
    logic               done_o;
    logic               go_nogo_o;
    logic [LBIST_W-1:0] signature_o;

    modport master (
        output start_i, resp_i,
        input  pattern_o, test_mode_o, core_rst_no, done_o, go_nogo_o, signature_o
    );

    modport slave (
        input  start_i, resp_i,
        output pattern_o, test_mode_o, core_rst_no, done_o, go_nogo_o, signature_o
    );

endinterface

// File: rtl/lbist_lfsr_step.sv
// -----------------------------------------------------------------------------
// lbist_lfsr_step
// Combinational next-state of a Galois shift register.
//   state_i : current register value
//   poly_i  : feedback polynomial
//   din_i   : word XORed into the shifted value (0 for a pure LFSR)
//   next_o  : next register value
// -----------------------------------------------------------------------------
module lbist_lfsr_step
    import lbist_pkg::*;
(
    input  logic [LBIST_W-1:0] state_i,
    input  logic [LBIST_W-1:0] poly_i,
    input  logic [LBIST_W-1:0] din_i,
    output logic [LBIST_W-1:0] next_o
);

    assign next_o = galois_step(state_i, poly_i, din_i);

endmodule

// File: rtl/lbist_controller.sv
// -----------------------------------------------------------------------------
// lbist_controller
// Logic-BIST controller: on a rising edge of start it puts the core into test
// mode, applies N_PATTERNS LFSR patterns, compacts the responses (arriving
// RESP_LATENCY cycles later) into a MISR and compares the final signature
// against GOLDEN_SIG. done/go_nogo hold until the next run or reset.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : lbist_controller_if.slave (handshake + core connection)
// -----------------------------------------------------------------------------
module lbist_controller
    import lbist_pkg::*;
#(
    parameter int unsigned        N_PATTERNS   = 1024,
    parameter int unsigned        RESP_LATENCY = 2,
    parameter logic [LBIST_W-1:0] LFSR_SEED    = LBIST_DEFAULT_SEED,
    parameter logic [LBIST_W-1:0] POLY         = LBIST_DEFAULT_POLY,
    parameter logic [LBIST_W-1:0] GOLDEN_SIG   = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    lbist_controller_if.slave     bus
);

    // RUN lasts long enough for the last pattern's response to come back.
    localparam int unsigned RUN_LEN = N_PATTERNS + RESP_LATENCY;
    localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(RESP_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lbist_state_e       state_q;
    logic               start_q;
    logic [LBIST_W-1:0] lfsr_q;
    logic [LBIST_W-1:0] lfsr_d;
    logic [LBIST_W-1:0] misr_q;
    logic [LBIST_W-1:0] misr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               test_mode_q;
    logic               core_rst_n_q;
    logic               done_q;
    logic               go_nogo_q;

    lbist_lfsr_step u_lfsr_step (
        .state_i (lfsr_q),
        .poly_i  (POLY),
        .din_i   ({LBIST_W{1'b0}}),
        .next_o  (lfsr_d)
    );

    lbist_lfsr_step u_misr_step (
        .state_i (misr_q),
        .poly_i  (POLY),
        .din_i   (bus.resp_i),
        .next_o  (misr_d)
    );

    // Controller FSM with registered outputs, LFSR/MISR/counter updates.
    // Output registers are set on the transition into each state so that
    // they always reflect the registered state, never start_i or resp_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            misr_q       <= {LBIST_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            test_mode_q  <= 1'b0;
            core_rst_n_q <= 1'b1;
            done_q       <= 1'b0;
            go_nogo_q    <= 1'b0;
        end else begin
            start_q <= bus.start_i;
            case (state_q)
                IDLE: begin
                    if (bus.start_i && !start_q) begin
                        state_q      <= INIT;
                        test_mode_q  <= 1'b1;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b0;
                        go_nogo_q    <= 1'b0;
                        misr_q       <= {LBIST_W{1'b0}};
                        cnt_q        <= {CNT_W{1'b0}};
                        lfsr_q       <= LFSR_SEED;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                INIT: begin
                    if (!bus.start_i) begin
                        state_q      <= IDLE;
                        test_mode_q  <= 1'b0;
                        core_rst_n_q <= 1'b1;
                        done_q       <= 1'b0;
                        go_nogo_q    <= 1'b0;
                    end else begin
                        state_q      <= RUN;
                        core_rst_n_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.start_i) begin
                        state_q      <= IDLE;
                        test_mode_q  <= 1'b0;
                        core_rst_n_q <= 1'b1;
                        done_q       <= 1'b0;
                        go_nogo_q    <= 1'b0;
                    end else begin
                        lfsr_q <= lfsr_d;
                        cnt_q  <= cnt_q + CNT_ONE;
                        // Responses only become meaningful once the pipeline
                        // to the core has filled.
                        if (cnt_q >= CNT_LAT) begin
                            misr_q <= misr_d;
                        end
                        if (cnt_q == CNT_LAST) begin
                            state_q      <= COMPARE;
                            core_rst_n_q <= 1'b0;
                        end
                    end
                end
                COMPARE: begin
                    state_q      <= DONE;
                    test_mode_q  <= 1'b0;
                    core_rst_n_q <= 1'b1;
                    done_q       <= 1'b1;
                    go_nogo_q    <= (misr_q == GOLDEN_SIG);
                end
                DONE: begin
                    if (!bus.start_i) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    test_mode_q  <= 1'b0;
                    core_rst_n_q <= 1'b1;
                    done_q       <= 1'b0;
                    go_nogo_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pattern_o   = lfsr_q;
    assign bus.signature_o = misr_q;
    assign bus.test_mode_o = test_mode_q;
    assign bus.core_rst_no = core_rst_n_q;
    assign bus.done_o      = done_q;
    assign bus.go_nogo_o   = go_nogo_q;

endmodule

// File: tb/tb_lbist_controller.sv
// -----------------------------------------------------------------------------
// tb_lbist_controller
// Self-checking bench for lbist_controller with N_PATTERNS=16, RESP_LATENCY=2.
// A behavioural core returns pattern_o delayed by two cycles; expected
// patterns and signatures come from an independent model of the LFSR/MISR.
// -----------------------------------------------------------------------------
module tb_lbist_controller;

    localparam int unsigned NPAT = 16;
    localparam int unsigned RLAT = 2;
    localparam logic [31:0] M_POLY = 32'h8020_0003;
    localparam logic [31:0] M_SEED = 32'hACE1_2468;

    function automatic logic [31:0] m_step(input logic [31:0] s, input logic [31:0] din);
        logic [31:0] r;
        r = {1'b0, s[31:1]} ^ din;
        if (s[0]) r = r ^ M_POLY;
        return r;
    endfunction

    function automatic logic [31:0] m_pat(input int idx);
        logic [31:0] p;
        p = M_SEED;
        for (int i = 0; i < idx; i++) p = m_step(p, 32'h0);
        return p;
    endfunction

    // Signature after compacting the first npat responses; response number
    // inv_idx has its bit 0 flipped (-1 = none).
    function automatic logic [31:0] m_sig(input int inv_idx, input int npat);
        logic [31:0] p;
        logic [31:0] m;
        logic [31:0] r;
        p = M_SEED;
        m = 32'h0;
        for (int i = 0; i < npat; i++) begin
            r = p;
            if (i == inv_idx) r[0] = ~r[0];
            m = m_step(m, r);
            p = m_step(p, 32'h0);
        end
        return m;
    endfunction

    localparam logic [31:0] GOLD = m_sig(-1, 16);

    logic clk;
    logic rst_ni;
    logic inv_en;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] pat5;
    int checks;
    int failures;

    lbist_controller_if bus();

    lbist_controller #(
        .N_PATTERNS   (NPAT),
        .RESP_LATENCY (RLAT),
        .LFSR_SEED    (M_SEED),
        .POLY         (M_POLY),
        .GOLDEN_SIG   (GOLD)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core: two-cycle response pipeline with optional fault on
    // the response belonging to pattern 5.
    always @(posedge clk) begin
        d1 <= bus.pattern_o;
        d2 <= d1;
    end
    assign bus.resp_i = (inv_en && (d2 == pat5)) ? (d2 ^ 32'h0000_0001) : d2;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with start_i already at its post-reset level; returns 1 ns after
    // a posedge so the next posedge samples start_i.
    task automatic do_reset(input logic start_val);
        rst_ni = 1'b0;
        bus.start_i = start_val;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // Counts posedges until done_o rises, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done_o && n < 60) begin
            step();
            n++;
        end
    endtask

    function automatic logic [67:0] outs();
        return {bus.test_mode_o, bus.core_rst_no, bus.done_o, bus.go_nogo_o,
                bus.pattern_o, bus.signature_o};
    endfunction

    function automatic logic [3:0] ctl();
        return {bus.test_mode_o, bus.core_rst_no, bus.done_o, bus.go_nogo_o};
    endfunction

    typedef struct {
        logic        start;
        logic [67:0] exp;   // {test_mode, core_rst_n, done, go_nogo, pattern, signature}
    } vec_t;

    vec_t tbl[31];

    initial begin
        int n;
        int upd;
        int pidx;
        logic tm;
        logic crn;
        logic dn;

        checks   = 0;
        failures = 0;
        inv_en   = 1'b0;
        pat5     = m_pat(5);
        bus.start_i = 1'b0;

        // Idle after reset: 10 cycles of reset values.
        for (int i = 0; i < 10; i++) begin
            tbl[i].start = 1'b0;
            tbl[i].exp   = {1'b0, 1'b1, 1'b0, 1'b0, M_SEED, 32'h0};
        end
        // Full passing run, one entry per posedge k+j (j = 0..20).
        for (int j = 0; j <= 20; j++) begin
            tm   = (j <= 19);
            crn  = !(j == 0 || j == 19);
            dn   = (j == 20);
            pidx = (j == 0) ? 0 : ((j - 1 > 18) ? 18 : j - 1);
            upd  = (j < 3) ? 0 : ((j - 3 > 16) ? 16 : j - 3);
            tbl[10 + j].start = 1'b1;
            tbl[10 + j].exp   = {tm, crn, dn, dn, m_pat(pidx), m_sig(-1, upd)};
        end

        do_reset(1'b0);
        chk("reset_state", outs(), {1'b0, 1'b1, 1'b0, 1'b0, M_SEED, 32'h0});
        for (int i = 0; i < 10; i++) begin
            bus.start_i = tbl[i].start;
            step();
            chk($sformatf("idle_vec%0d", i), outs(), tbl[i].exp);
        end

        // Start high at reset release counts as an edge.
        do_reset(1'b1);
        for (int i = 10; i < 31; i++) begin
            bus.start_i = tbl[i].start;
            step();
            chk($sformatf("run_vec%0d", i - 10), outs(), tbl[i].exp);
        end

        // Result holds through DONE/IDLE; restart clears it and reruns cleanly.
        bus.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold_go%0d", i), 68'(ctl()), 68'(4'b0111));
        end
        bus.start_i = 1'b1;
        step();
        chk("rerun_init", 68'(ctl()), 68'(4'b1000));
        wait_done(n);
        chk("rerun_latency", 68'(n), 68'(20));
        chk("rerun_go", 68'(bus.go_nogo_o), 68'(1'b1));
        chk("rerun_sig", 68'(bus.signature_o), 68'(GOLD));

        // Corrupted response for pattern 5: completes with no-go.
        inv_en = 1'b1;
        do_reset(1'b1);
        step();
        chk("fail_init", 68'(ctl()), 68'(4'b1000));
        wait_done(n);
        chk("fail_latency", 68'(n), 68'(20));
        chk("fail_go", 68'(ctl()), 68'(4'b0110));
        chk("fail_sig", 68'(bus.signature_o), 68'(m_sig(5, 16)));
        chk("fail_sig_ne_gold", 68'(bus.signature_o != GOLD), 68'(1'b1));
        inv_en = 1'b0;

        // Abort at RUN cnt=8.
        bus.start_i = 1'b0;
        step();
        bus.start_i = 1'b1;
        step();
        repeat (9) step();
        chk("abort_pre", 68'(ctl()), 68'(4'b1100));
        chk("abort_pre_pat", 68'(bus.pattern_o), 68'(m_pat(8)));
        bus.start_i = 1'b0;
        step();
        chk("abort_idle", 68'(ctl()), 68'(4'b0100));
        step();
        chk("abort_stay", 68'(ctl()), 68'(4'b0100));

        // Asynchronous reset mid-RUN, then a fresh run.
        bus.start_i = 1'b1;
        step();
        repeat (6) step();
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_rst", outs(), {1'b0, 1'b1, 1'b0, 1'b0, M_SEED, 32'h0});
        #1;
        rst_ni = 1'b1;
        step();
        chk("post_rst_init", 68'(ctl()), 68'(4'b1000));
        wait_done(n);
        chk("post_rst_latency", 68'(n), 68'(20));
        chk("post_rst_go", 68'(ctl()), 68'(4'b0111));
        chk("post_rst_sig", 68'(bus.signature_o), 68'(GOLD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
